// File: rtl/vec_wb_arbiter.sv
// Three-way round-robin arbiter feeding a one-entry vector writeback stage.
// Ports: clk/rst, req_valid/req_ready + per-source data/addr in; wb_* out.
module vec_wb_arbiter #(
    parameter int N = 16,
    parameter int M = 16,
    parameter int A = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          req_valid,
    output logic [2:0]          req_ready,
    input  logic [M-1:0][N-1:0] req_data0,
    input  logic [M-1:0][N-1:0] req_data1,
    input  logic [M-1:0][N-1:0] req_data2,
    input  logic [A-1:0]        req_addr0,
    input  logic [A-1:0]        req_addr1,
    input  logic [A-1:0]        req_addr2,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [M-1:0][N-1:0] wb_data,
    output logic [A-1:0]        wb_addr,
    output logic [1:0]          wb_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_q, rr_d;
    logic [M-1:0][N-1:0] data_q, data_d;
    logic [A-1:0]        addr_q, addr_d;
    logic [1:0]          sel_q, sel_d;

    logic                load_en;
    logic                gnt_vld;
    logic [1:0]          gnt_idx;
    logic [2:0]          cand;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            rr_q    <= 2'd0;
            data_q  <= '0;
            addr_q  <= '0;
            sel_q   <= 2'b11;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        data_d    = data_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        gnt_vld   = 1'b0;
        gnt_idx   = 2'd0;
        cand      = 3'd0;
        req_ready = 3'b000;

        load_en = (state_q == EMPTY) || wb_ready;

        // Walk rr_q+2 down to rr_q so the nearest source to the pointer wins.
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, rr_q} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (req_valid[cand[1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[1:0];
            end
        end

        if (load_en && !rst && gnt_vld) begin
            req_ready = 3'b001 << gnt_idx;
            state_d   = FULL;
            sel_d     = gnt_idx;
            rr_d      = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            unique case (gnt_idx)
                2'd0: begin
                    data_d = req_data0;
                    addr_d = req_addr0;
                end
                2'd1: begin
                    data_d = req_data1;
                    addr_d = req_addr1;
                end
                default: begin
                    data_d = req_data2;
                    addr_d = req_addr2;
                end
            endcase
        end else if (state_q == FULL && wb_ready) begin
            // Drain: data/addr keep their last value, only sel goes idle.
            state_d = EMPTY;
            sel_d   = 2'b11;
        end
    end

    assign wb_valid = (state_q == FULL);
    assign wb_data  = data_q;
    assign wb_addr  = addr_q;
    assign wb_sel   = sel_q;

endmodule

// File: doc/vec_wb_arbiter.md
Name: vec_wb_arbiter

Overview:
- Three-way round-robin arbiter and writeback scheduler for the vector register file write port.
- Sources: 0 = vector ALU, 1 = vector load unit, 2 = vector immediate/broadcast path.
- Accepts valid/ready requests carrying a full M×N vector and a destination register index, and grants one source per cycle.
- Registers the granted vector into a one-entry output stage, and drives the 2-bit source select using the 3:1 vector mux encoding (00/01/10; 11 = none).

Parameters:
- N, 16, element width in bits
- M, 16, elements per vector
- A, 4, destination register index width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  3  per-source request valid (bit i = source i)
- req_ready  out  3  per-source accept, combinational, one-hot or zero
- req_data0  in  [M-1:0][N-1:0]  source 0 vector
- req_data1  in  [M-1:0][N-1:0]  source 1 vector
- req_data2  in  [M-1:0][N-1:0]  source 2 vector
- req_addr0  in  A  source 0 destination register
- req_addr1  in  A  source 1 destination register
- req_addr2  in  A  source 2 destination register
- wb_valid  out  1  output stage holds a write
- wb_ready  in  1  register file consumes the write this cycle
- wb_data  out  [M-1:0][N-1:0]  vector to write
- wb_addr  out  A  destination register
- wb_sel  out  2  source of the held write: 00/01/10; 11 when wb_valid=0

Behaviour:
- Reset (rst=1 at a clk edge): wb_valid=0, wb_data=0, wb_addr=0, wb_sel=2'b11, rr_ptr=0. Any held write is discarded.
- Load enable: load_en = !wb_valid || wb_ready. This allows back-to-back throughput of one write per cycle.
- Grant (combinational):
  - Only when load_en=1 and rst=0.
  - Pick the first source with req_valid set, searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - req_ready = one-hot of the winner; req_ready=0 when load_en=0 or no request.
- Handshake: a transfer from source i occurs when req_valid[i] && req_ready[i]. A source must hold valid, data and addr stable until accepted. req_valid has no combinational path to itself.
- State 0 — EMPTY (wb_valid=0):
  - On grant g: next cycle wb_valid=1, wb_data/wb_addr latch source g, wb_sel=g.
  - Latency is 1 cycle from accept to wb_valid.
- State 1 — FULL (wb_valid=1):
  - wb_ready=0: hold data, addr and sel unchanged; req_ready=0.
  - wb_ready=1 with a grant: replace the held write with the new one (no bubble).
  - wb_ready=1 with no request: go to EMPTY, wb_sel=11, wb_data/wb_addr hold their last value.
- rr_ptr update: on every grant, rr_ptr <= (g==2) ? 0 : g+1. Otherwise unchanged. rr_ptr is 2 bits; value 3 is never reached. Fairness is strict: with all three sources continuously valid, grants are 0,1,2,0,…
- Simultaneous rst and requests: rst wins, no transfer, req_ready still 0 during the rst cycle.
- wb_sel feeds the external 3:1 vector mux select directly. The 11 encoding selects zero there; it is never driven while wb_valid=1.
- No data arithmetic; vectors pass bit-exact.

Test Plan:
- Reset, then no requests for 5 cycles -> wb_valid=0, wb_sel=11, req_ready=000 every cycle.
- Single request: req_valid=010, data1 = all elements 16'h00A5, addr1=4'h7 -> req_ready=010 same cycle; next cycle wb_valid=1, wb_sel=01, wb_addr=7, wb_data elements 00A5; rr_ptr=2.
- Round-robin: req_valid=111 held, wb_ready=1 for 6 cycles from reset -> grant order 0,1,2,0,1,2; wb_sel sequence 00,01,10,00,01,10 one cycle later, no bubbles.
- Backpressure: wb_valid=1, wb_ready=0 for 3 cycles with req_valid=101 -> req_ready=000, wb outputs frozen. When wb_ready=1, the correct round-robin winner is granted that cycle and replaces the held write.
- Drain: wb_valid=1, wb_ready=1, req_valid=000 -> next cycle wb_valid=0, wb_sel=11, rr_ptr unchanged.
- Reset mid-operation: wb_valid=1 with wb_ready=0, assert rst one cycle with req_valid=111 -> req_ready=000. Next cycle wb_valid=0, wb_data=0, wb_sel=11; the first grant after reset goes to source 0.
